sd_sector_read_arbiter: RTL and testbench

- Shares one sd_spi_sector_reader between two requesters, for example a file-system walker and a bulk streamer.
- Each requester asks for a burst of consecutive sectors. The block grants the requesters round-robin and sequences the reader's level-held start/done handshake once per sector.
- It advances the LBA, forwards the read byte stream tagged with owner and sector index, and checks that every sector delivers exactly 512 bytes.

---
 rtl/sd_sector_read_arbiter.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sd_sector_read_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_read_arbiter.sv
// sd_sector_read_arbiter
// Shares one SPI sector reader between two burst requesters. Requesters are
// granted round-robin. Each granted burst is walked one sector at a time
// through the reader's level-held start/done handshake. The read byte stream
// is forwarded, tagged with the owner and the sector index inside the burst.
// Every sector is checked for exactly 512 delivered bytes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN, reqN_lba, reqN_cnt level request with first LBA and sector count (0 => 1)
//   gntN                     high for the whole burst of owner N
//   doneN, err               one-cycle completion pulse; err flags a bad byte count
//   rd_start, rd_sector_no   handshake towards the sector reader
//   rd_done, rd_rvalid,
//   rd_raddr, rd_rdata       handshake and byte stream from the sector reader
//   out_valid, out_owner,
//   out_sidx, out_addr,
//   out_data                 registered, tagged byte stream
module sd_sector_read_arbiter #(
  parameter int LBA_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [LBA_W-1:0] req0_lba,
  input  logic [CNT_W-1:0] req0_cnt,
  input  logic             req1,
  input  logic [LBA_W-1:0] req1_lba,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             err,
  output logic             rd_start,
  output logic [LBA_W-1:0] rd_sector_no,
  input  logic             rd_done,
  input  logic             rd_rvalid,
  input  logic [8:0]       rd_raddr,
  input  logic [7:0]       rd_rdata,
  output logic             out_valid,
  output logic             out_owner,
  output logic [CNT_W-1:0] out_sidx,
  output logic [8:0]       out_addr,
  output logic [7:0]       out_data
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_NEXT   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LBA_W-1:0] LBA_ZERO = {LBA_W{1'b0}};
  localparam logic [LBA_W-1:0] LBA_ONE  = {{(LBA_W-1){1'b0}}, 1'b1};
  localparam logic [9:0]       SECTOR_BYTES = 10'd512;

  // Saturating 10-bit byte counter increment (stops at 1023).
  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    if (v == 10'd1023) begin
      sat_inc10 = v;
    end else begin
      sat_inc10 = v + 10'd1;
    end
  endfunction

  state_t           state_r, next_state_s;
  logic             last_owner_r, last_owner_s;
  logic             owner_r, owner_s;
  logic [LBA_W-1:0] lba_r, lba_s;
  logic [CNT_W-1:0] remaining_r, remaining_s;
  logic [CNT_W-1:0] sidx_r, sidx_s;
  logic [9:0]       bytecnt_r, bytecnt_s, bytecnt_inc_s;
  logic             errflag_r, errflag_s;

  logic             gnt0_s, gnt1_s, done0_s, done1_s, err_s;
  logic             rd_start_s;
  logic [LBA_W-1:0] rd_sector_no_s;
  logic             out_valid_s;
  logic             pick1_s;
  logic             any_req_s;

  // req1 wins when it is alone, or on a tie when req0 owned the last burst.
  assign pick1_s   = req1 & (~req0 | ~last_owner_r);
  assign any_req_s = req0 | req1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          next_state_s = ST_ISSUE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ISSUE: next_state_s = ST_WAIT;
      ST_WAIT: begin
        if (rd_done) begin
          next_state_s = ST_NEXT;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_NEXT: begin
        if (remaining_r == CNT_ONE) begin
          next_state_s = ST_FINISH;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      ST_FINISH: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output and datapath next-value logic; everything is registered below.
  always_comb begin
    last_owner_s   = last_owner_r;
    owner_s        = owner_r;
    lba_s          = lba_r;
    remaining_s    = remaining_r;
    sidx_s         = sidx_r;
    bytecnt_s      = bytecnt_r;
    errflag_s      = errflag_r;
    gnt0_s         = gnt0;
    gnt1_s         = gnt1;
    done0_s        = 1'b0;
    done1_s        = 1'b0;
    err_s          = 1'b0;
    rd_start_s     = rd_start;
    rd_sector_no_s = rd_sector_no;
    // Byte count including a beat arriving in the current cycle.
    if (rd_rvalid) begin
      bytecnt_inc_s = sat_inc10(bytecnt_r);
    end else begin
      bytecnt_inc_s = bytecnt_r;
    end
    // Stray beats with no active grant are neither forwarded nor counted.
    out_valid_s    = rd_rvalid & (gnt0 | gnt1);

    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          owner_s   = pick1_s;
          gnt0_s    = ~pick1_s;
          gnt1_s    = pick1_s;
          sidx_s    = CNT_ZERO;
          bytecnt_s = 10'd0;
          errflag_s = 1'b0;
          if (pick1_s) begin
            lba_s       = req1_lba;
            remaining_s = (req1_cnt == CNT_ZERO) ? CNT_ONE : req1_cnt;
          end else begin
            lba_s       = req0_lba;
            remaining_s = (req0_cnt == CNT_ZERO) ? CNT_ONE : req0_cnt;
          end
        end else begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      end
      ST_ISSUE: begin
        rd_start_s     = 1'b1;
        rd_sector_no_s = lba_r;
      end
      ST_WAIT: begin
        bytecnt_s = bytecnt_inc_s;
        if (rd_done) begin
          rd_start_s = 1'b0;
          if (bytecnt_inc_s != SECTOR_BYTES) begin
            errflag_s = 1'b1;
          end else begin
            errflag_s = errflag_r;
          end
        end else begin
          rd_start_s = 1'b1;
        end
      end
      ST_NEXT: begin
        rd_start_s  = 1'b0;
        lba_s       = lba_r + LBA_ONE;
        remaining_s = remaining_r - CNT_ONE;
        sidx_s      = sidx_r + CNT_ONE;
        bytecnt_s   = 10'd0;
        // Completion pulse is raised on entry to FINISH so it is registered.
        if (remaining_r == CNT_ONE) begin
          done0_s = ~owner_r;
          done1_s = owner_r;
          err_s   = errflag_r;
        end else begin
          done0_s = 1'b0;
          done1_s = 1'b0;
        end
      end
      ST_FINISH: begin
        gnt0_s       = 1'b0;
        gnt1_s       = 1'b0;
        last_owner_s = owner_r;
      end
      default: begin
        gnt0_s     = 1'b0;
        gnt1_s     = 1'b0;
        rd_start_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner_r <= 1'b1;
      owner_r      <= 1'b0;
      lba_r        <= LBA_ZERO;
      remaining_r  <= CNT_ZERO;
      sidx_r       <= CNT_ZERO;
      bytecnt_r    <= 10'd0;
      errflag_r    <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err          <= 1'b0;
      rd_start     <= 1'b0;
      rd_sector_no <= LBA_ZERO;
      out_valid    <= 1'b0;
      out_owner    <= 1'b0;
      out_sidx     <= CNT_ZERO;
      out_addr     <= 9'd0;
      out_data     <= 8'd0;
    end else begin
      last_owner_r <= last_owner_s;
      owner_r      <= owner_s;
      lba_r        <= lba_s;
      remaining_r  <= remaining_s;
      sidx_r       <= sidx_s;
      bytecnt_r    <= bytecnt_s;
      errflag_r    <= errflag_s;
      gnt0         <= gnt0_s;
      gnt1         <= gnt1_s;
      done0        <= done0_s;
      done1        <= done1_s;
      err          <= err_s;
      rd_start     <= rd_start_s;
      rd_sector_no <= rd_sector_no_s;
      out_valid    <= out_valid_s;
      out_owner    <= owner_r;
      out_sidx     <= sidx_r;
      out_addr     <= rd_raddr;
      out_data     <= rd_rdata;
    end
  end

endmodule

// File: tb/tb_sd_sector_read_arbiter.sv
// Directed self-checking bench for sd_sector_read_arbiter. A behavioural
// sector reader answers rd_start with a configurable number of bytes then
// holds done until start drops; a monitor tallies the tagged output stream.
module tb_sd_sector_read_arbiter;
  logic        clk, rst;
  logic        req0, req1;
  logic [31:0] req0_lba, req1_lba;
  logic [7:0]  req0_cnt, req1_cnt;
  logic        gnt0, gnt1, done0, done1, err;
  logic        rd_start;
  logic [31:0] rd_sector_no;
  logic        rd_done, rd_rvalid;
  logic [8:0]  rd_raddr;
  logic [7:0]  rd_rdata;
  logic        out_valid, out_owner;
  logic [7:0]  out_sidx;
  logic [8:0]  out_addr;
  logic [7:0]  out_data;

  int checks = 0;
  int errors = 0;
  int nbytes = 512;

  // Model / monitor records
  logic [31:0] sectors[$];
  int          done_q[$];
  int          err_q[$];
  int          gnt_q[$];
  int          vcnt_own[2];
  int          sidx_hist[256];
  int          data_bad;

  sd_sector_read_arbiter #(.LBA_W(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req0_lba(req0_lba), .req0_cnt(req0_cnt),
    .req1(req1), .req1_lba(req1_lba), .req1_cnt(req1_cnt),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .rd_start(rd_start), .rd_sector_no(rd_sector_no),
    .rd_done(rd_done), .rd_rvalid(rd_rvalid), .rd_raddr(rd_raddr), .rd_rdata(rd_rdata),
    .out_valid(out_valid), .out_owner(out_owner), .out_sidx(out_sidx),
    .out_addr(out_addr), .out_data(out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sector reader model
  initial begin
    int phase;
    int cnt;
    logic [31:0] cur;
    phase = 0; cnt = 0; cur = 32'd0;
    rd_done = 1'b0; rd_rvalid = 1'b0; rd_raddr = 9'd0; rd_rdata = 8'd0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        phase = 0; rd_done = 1'b0; rd_rvalid = 1'b0;
      end else begin
        case (phase)
          0: begin
            rd_rvalid = 1'b0;
            if (rd_start && !rd_done) begin
              sectors.push_back(rd_sector_no);
              cur = rd_sector_no;
              cnt = 0;
              phase = 1;
            end
          end
          1: begin
            if (cnt < nbytes) begin
              rd_rvalid = 1'b1;
              rd_raddr = cnt[8:0];
              rd_rdata = cnt[7:0] ^ 8'h5A;
              cnt++;
            end else begin
              rd_rvalid = 1'b0;
              rd_done = 1'b1;
              phase = 2;
            end
          end
          default: begin
            rd_rvalid = 1'b0;
            if (!rd_start) begin
              rd_done = 1'b0;
              phase = 0;
            end
          end
        endcase
      end
    end
  end

  // Output monitor
  initial begin
    logic p0, p1;
    p0 = 1'b0; p1 = 1'b0; data_bad = 0;
    vcnt_own[0] = 0; vcnt_own[1] = 0;
    for (int i = 0; i < 256; i++) sidx_hist[i] = 0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        vcnt_own[out_owner]++;
        sidx_hist[out_sidx]++;
        if (out_data !== (out_addr[7:0] ^ 8'h5A)) data_bad++;
      end
      if (done0 === 1'b1) begin done_q.push_back(0); err_q.push_back(int'(err)); end
      if (done1 === 1'b1) begin done_q.push_back(1); err_q.push_back(int'(err)); end
      if (gnt0 === 1'b1 && !p0) gnt_q.push_back(0);
      if (gnt1 === 1'b1 && !p1) gnt_q.push_back(1);
      p0 = gnt0; p1 = gnt1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_dones(input int target);
    int n;
    n = 0;
    while (done_q.size() < target && n < 6000) begin tick(); n++; end
    chk("done_timeout", 64'(done_q.size() >= target), 64'd1);
  endtask

  task automatic burst(input bit who, input logic [31:0] lba, input logic [7:0] cnt);
    int t;
    t = done_q.size() + 1;
    if (!who) begin req0 = 1'b1; req0_lba = lba; req0_cnt = cnt; end
    else begin req1 = 1'b1; req1_lba = lba; req1_cnt = cnt; end
    wait_dones(t);
    if (!who) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {gnt0, gnt1, done0, done1, err, rd_start, out_valid, out_owner},
        64'd0);
    chk({tag, "_sector_no"}, rd_sector_no, 64'd0);
    chk({tag, "_out_bus"}, {out_sidx, out_addr, out_data}, 64'd0);
  endtask

  initial begin
    int sb, dq, n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    req0_lba = 32'd0; req1_lba = 32'd0; req0_cnt = 8'd0; req1_cnt = 8'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Single 3-sector burst with grant/start latency checks
    req0 = 1'b1; req0_lba = 32'h100; req0_cnt = 8'd3;
    tick();
    chk("gnt_latency", {gnt0, gnt1, rd_start}, 64'b100);
    tick();
    chk("start_rise", rd_start, 64'd1);
    chk("first_sector_no", rd_sector_no, 64'h100);
    wait_dones(1);
    req0 = 1'b0;
    chk("b1_done_owner", done_q[0], 64'd0);
    chk("b1_err", err_q[0], 64'd0);
    chk("b1_nsect", sectors.size(), 64'd3);
    chk("b1_sect0", sectors[0], 64'h100);
    chk("b1_sect1", sectors[1], 64'h101);
    chk("b1_sect2", sectors[2], 64'h102);
    chk("b1_bytes_own0", vcnt_own[0], 64'd1536);
    chk("b1_bytes_own1", vcnt_own[1], 64'd0);
    chk("b1_sidx0", sidx_hist[0], 64'd512);
    chk("b1_sidx1", sidx_hist[1], 64'd512);
    chk("b1_sidx2", sidx_hist[2], 64'd512);

    // Tie straight after reset: req0 first, req1 after one idle cycle
    tick(); rst = 1'b1; tick(); rst = 1'b0; tick();
    dq = done_q.size();
    req0 = 1'b1; req0_lba = 32'h10; req0_cnt = 8'd1;
    req1 = 1'b1; req1_lba = 32'h20; req1_cnt = 8'd1;
    wait_dones(dq + 1);
    req0 = 1'b0;
    chk("tie1_first", done_q[dq], 64'd0);
    tick();
    chk("tie1_idle_gap", {gnt0, gnt1, rd_start}, 64'd0);
    tick();
    chk("tie1_gnt1", {gnt0, gnt1}, 64'b01);
    wait_dones(dq + 2);
    req1 = 1'b0;
    chk("tie1_second", done_q[dq + 1], 64'd1);
    chk("tie1_gnt_order", {gnt_q[gnt_q.size()-2], gnt_q[gnt_q.size()-1]}, {32'd0, 32'd1});

    // req0 owns last, then tie: req1 must win
    tick();
    burst(1'b0, 32'h30, 8'd1);
    tick();
    dq = done_q.size();
    req0 = 1'b1; req0_lba = 32'h50; req0_cnt = 8'd1;
    req1 = 1'b1; req1_lba = 32'h60; req1_cnt = 8'd1;
    wait_dones(dq + 1);
    req1 = 1'b0;
    chk("tie2_first", done_q[dq], 64'd1);
    wait_dones(dq + 2);
    req0 = 1'b0;
    chk("tie2_second", done_q[dq + 1], 64'd0);
    tick();

    // cnt = 0 treated as one sector
    sb = sectors.size();
    burst(1'b1, 32'd5, 8'd0);
    chk("cnt0_nsect", sectors.size() - sb, 64'd1);
    chk("cnt0_lba", sectors[sb], 64'd5);
    chk("cnt0_owner", done_q[done_q.size()-1], 64'd1);
    chk("cnt0_err", err_q[err_q.size()-1], 64'd0);
    tick();

    // Short sectors: 511 bytes each -> err with done0, LBA still advances
    nbytes = 511;
    sb = sectors.size();
    burst(1'b0, 32'h40, 8'd2);
    nbytes = 512;
    chk("short_err", err_q[err_q.size()-1], 64'd1);
    chk("short_owner", done_q[done_q.size()-1], 64'd0);
    chk("short_nsect", sectors.size() - sb, 64'd2);
    chk("short_sect1", sectors[sb + 1], 64'h41);
    tick();

    // LBA wrap
    sb = sectors.size();
    burst(1'b0, 32'hFFFF_FFFF, 8'd2);
    chk("wrap_sect0", sectors[sb], 64'hFFFF_FFFF);
    chk("wrap_sect1", sectors[sb + 1], 64'h0);
    chk("wrap_err", err_q[err_q.size()-1], 64'd0);
    tick();

    // Reset during WAIT of sector 1 of a 4-sector burst
    sb = sectors.size();
    dq = done_q.size();
    req0 = 1'b1; req0_lba = 32'h200; req0_cnt = 8'd4;
    n = 0;
    while (sectors.size() < sb + 2 && n < 3000) begin tick(); n++; end
    chk("rst_reach_sector1", 64'(sectors.size() >= sb + 2), 64'd1);
    repeat (20) tick();
    chk("rst_in_wait", {gnt0, rd_start}, 64'b11);
    rst = 1'b1;
    req0 = 1'b0;
    tick();
    chk_all_zero("midrst");
    rst = 1'b0;
    repeat (5) tick();
    chk("midrst_no_done", done_q.size(), 64'(dq));
    chk("midrst_idle", {gnt0, gnt1, rd_start}, 64'd0);
    sb = sectors.size();
    burst(1'b1, 32'h300, 8'd1);
    chk("post_rst_nsect", sectors.size() - sb, 64'd1);
    chk("post_rst_lba", sectors[sb], 64'h300);
    chk("post_rst_owner", done_q[done_q.size()-1], 64'd1);
    chk("data_tagging", data_bad, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
